id_ex_hazard_ctrl: RTL and testbench

Hazard and stall controller that generates the control inputs consumed by the ID/EX pipeline register and the IF/ID and PC stages: the bubble/flush (IDEX_RESET), stall and flush strobes. It detects load-use hazards, taken-branch/jump flushes and multi-cycle M-extension divide occupancy. It also holds a branch flush that arrives while memory is busy until the flush can take effect. It sits in the ID stage, beside the register file, and observes the IDEX outputs and the EX branch result.

---
 rtl/id_ex_hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_div_counter.sv | 34 +++
 rtl/id_ex_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the ID/EX hazard controller and the divider unit.
package id_ex_hazard_ctrl_pkg;

    localparam int unsigned DIV_LATENCY_DEFAULT = 32;
    localparam int unsigned DIV_CNT_W           = 6;

    typedef enum logic [1:0] {
        HAZ_RUN        = 2'd0,
        HAZ_DIV_WAIT   = 2'd1,
        HAZ_FLUSH_PEND = 2'd2
    } haz_state_e;

endpackage

// File: rtl/hazard_div_counter.sv
// Loadable down-counter tracking remaining divide occupancy; saturates at zero.
module hazard_div_counter #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID-stage hazard controller: load-use bubbles, branch flushes (deferred across memory
// busywait) and multi-cycle divide occupancy. Outputs are Mealy on state and inputs.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       MEM_BUSYWAIT,
    input  logic [4:0] RS1_ADDR_ID,
    input  logic [4:0] RS2_ADDR_ID,
    input  logic       RS1_USE_ID,
    input  logic       RS2_USE_ID,
    input  logic       MEM_READ_EN_IDEX,
    input  logic [4:0] REG_WRITE_ADDR_IDEX,
    input  logic       DIV_OP_IDEX,
    input  logic       BRANCH_TAKEN_EX,
    output logic       PC_STALL,
    output logic       IFID_STALL,
    output logic       IFID_FLUSH,
    output logic       IDEX_RESET,
    output logic       IDEX_HOLD,
    output logic       DIV_BUSY,
    output logic [1:0] HAZ_STATE
);

    // Entry cycle is the first occupancy cycle, so the counter covers the remaining ones.
    localparam logic [DIV_CNT_W-1:0] DivLoad = DIV_CNT_W'(DIV_LATENCY - 1);

    haz_state_e state_q, state_d;
    logic       flush_pending_q, flush_pending_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       load_use;
    logic       do_flush;

    hazard_div_counter #(
        .Width (DIV_CNT_W)
    ) u_div_cnt (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .load_i     (cnt_load),
        .load_val_i (DivLoad),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign load_use = MEM_READ_EN_IDEX && (REG_WRITE_ADDR_IDEX != 5'd0) &&
                      ((RS1_USE_ID && (RS1_ADDR_ID == REG_WRITE_ADDR_IDEX)) ||
                       (RS2_USE_ID && (RS2_ADDR_ID == REG_WRITE_ADDR_IDEX)));

    // A branch cannot resolve while a divide holds EX, so DIV_WAIT ignores it.
    assign do_flush = flush_pending_q || (BRANCH_TAKEN_EX && (state_q != HAZ_DIV_WAIT));

    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
        PC_STALL        = 1'b0;
        IFID_STALL      = 1'b0;
        IFID_FLUSH      = 1'b0;
        IDEX_RESET      = 1'b0;
        IDEX_HOLD       = 1'b0;
        DIV_BUSY        = 1'b0;

        if (MEM_BUSYWAIT) begin
            DIV_BUSY = (state_q == HAZ_DIV_WAIT);
            if (BRANCH_TAKEN_EX) begin
                flush_pending_d = 1'b1;
                state_d         = HAZ_FLUSH_PEND;
            end
        end else if (do_flush) begin
            IFID_FLUSH      = 1'b1;
            IDEX_RESET      = 1'b1;
            flush_pending_d = 1'b0;
            state_d         = HAZ_RUN;
        end else begin
            case (state_q)
                HAZ_RUN: begin
                    if (DIV_OP_IDEX) begin
                        PC_STALL   = 1'b1;
                        IFID_STALL = 1'b1;
                        IDEX_HOLD  = 1'b1;
                        DIV_BUSY   = 1'b1;
                        cnt_load   = 1'b1;
                        state_d    = HAZ_DIV_WAIT;
                    end else if (load_use) begin
                        PC_STALL   = 1'b1;
                        IFID_STALL = 1'b1;
                        IDEX_RESET = 1'b1;
                    end
                end
                HAZ_DIV_WAIT: begin
                    if (!cnt_zero) begin
                        PC_STALL   = 1'b1;
                        IFID_STALL = 1'b1;
                        IDEX_HOLD  = 1'b1;
                        DIV_BUSY   = 1'b1;
                        cnt_dec    = 1'b1;
                    end else begin
                        state_d = HAZ_RUN;
                    end
                end
                default: begin
                    state_d         = HAZ_RUN;
                    flush_pending_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q         <= HAZ_RUN;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign HAZ_STATE = state_q;

    a_no_branch_in_div : assert property (@(posedge CLK) disable iff (!RESET_N)
        !((state_q == HAZ_DIV_WAIT) && BRANCH_TAKEN_EX));

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_id_ex_hazard_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic       MEM_BUSYWAIT;
    logic [4:0] RS1_ADDR_ID;
    logic [4:0] RS2_ADDR_ID;
    logic       RS1_USE_ID;
    logic       RS2_USE_ID;
    logic       MEM_READ_EN_IDEX;
    logic [4:0] REG_WRITE_ADDR_IDEX;
    logic       DIV_OP_IDEX;
    logic       BRANCH_TAKEN_EX;
    logic       PC_STALL;
    logic       IFID_STALL;
    logic       IFID_FLUSH;
    logic       IDEX_RESET;
    logic       IDEX_HOLD;
    logic       DIV_BUSY;
    logic [1:0] HAZ_STATE;

    id_ex_hazard_ctrl #(
        .DIV_LATENCY (32)
    ) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .MEM_BUSYWAIT        (MEM_BUSYWAIT),
        .RS1_ADDR_ID         (RS1_ADDR_ID),
        .RS2_ADDR_ID         (RS2_ADDR_ID),
        .RS1_USE_ID          (RS1_USE_ID),
        .RS2_USE_ID          (RS2_USE_ID),
        .MEM_READ_EN_IDEX    (MEM_READ_EN_IDEX),
        .REG_WRITE_ADDR_IDEX (REG_WRITE_ADDR_IDEX),
        .DIV_OP_IDEX         (DIV_OP_IDEX),
        .BRANCH_TAKEN_EX     (BRANCH_TAKEN_EX),
        .PC_STALL            (PC_STALL),
        .IFID_STALL          (IFID_STALL),
        .IFID_FLUSH          (IFID_FLUSH),
        .IDEX_RESET          (IDEX_RESET),
        .IDEX_HOLD           (IDEX_HOLD),
        .DIV_BUSY            (DIV_BUSY),
        .HAZ_STATE           (HAZ_STATE)
    );

    // {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_RESET, IDEX_HOLD, DIV_BUSY, HAZ_STATE[1:0]}
    localparam logic [7:0] E_IDLE     = 8'b0000_0000;
    localparam logic [7:0] E_LU       = 8'b1101_0000;
    localparam logic [7:0] E_FL       = 8'b0011_0000;
    localparam logic [7:0] E_FL_PEND  = 8'b0011_0010;
    localparam logic [7:0] E_PEND     = 8'b0000_0010;
    localparam logic [7:0] E_DIV_IN   = 8'b1100_1100;
    localparam logic [7:0] E_DIV_WAIT = 8'b1100_1101;
    localparam logic [7:0] E_DIV_DONE = 8'b0000_0001;
    localparam logic [7:0] E_DIV_FRZ  = 8'b0000_0101;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        logic [7:0] got;
        logic [7:0] want;
        string      nm;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_RESET, IDEX_HOLD, DIV_BUSY,
                    HAZ_STATE};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, want, $time);
            end
        end
    end

    task automatic expect_now(input logic [7:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue expectation, advance.
    task automatic vec(input logic busy, input logic br, input logic div, input logic mr,
                       input logic [4:0] wa, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [7:0] e, input string n);
        MEM_BUSYWAIT        = busy;
        BRANCH_TAKEN_EX     = br;
        DIV_OP_IDEX         = div;
        MEM_READ_EN_IDEX    = mr;
        REG_WRITE_ADDR_IDEX = wa;
        RS1_ADDR_ID         = rs1;
        RS1_USE_ID          = u1;
        RS2_ADDR_ID         = rs2;
        RS2_USE_ID          = u2;
        expect_now(e, n);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic [7:0] e, input string n);
        vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, e, n);
    endtask

    task automatic div_cyc(input logic busy, input logic [7:0] e, input string n);
        vec(busy, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, e, n);
    endtask

    initial begin
        RESET_N = 1'b0;
        MEM_BUSYWAIT = 1'b0; BRANCH_TAKEN_EX = 1'b0; DIV_OP_IDEX = 1'b0;
        MEM_READ_EN_IDEX = 1'b0; REG_WRITE_ADDR_IDEX = 5'd0;
        RS1_ADDR_ID = 5'd0; RS2_ADDR_ID = 5'd0; RS1_USE_ID = 1'b0; RS2_USE_ID = 1'b0;
        @(posedge CLK);
        #1;
        expect_now(E_IDLE, "reset_state");
        @(posedge CLK);
        #3 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        idle(E_IDLE, "post_reset_idle");

        // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID
        vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, E_LU, "lu_rs1");
        vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd1, 1'b1, E_IDLE, "lu_after");
        vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, E_IDLE, "lu_x0");
        vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, E_LU, "lu_rs2");
        vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, E_IDLE, "lu_rs1_unused");
        vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, E_IDLE, "lu_not_load");

        // Branch flush, and flush outranking a simultaneous load-use
        vec(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_FL, "br_flush");
        idle(E_IDLE, "br_after");
        vec(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, E_FL, "br_over_lu");
        idle(E_IDLE, "br_over_lu_after");

        // Flush deferred across 4 cycles of busywait
        vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE, "pend_first");
        for (int i = 0; i < 3; i++) begin
            vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_PEND, "pend_hold");
        end
        vec(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_FL_PEND, "pend_flush");
        idle(E_IDLE, "pend_after");

        // Divide, latency 32; load-use inputs also present on the entry cycle
        vec(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, E_DIV_IN, "div_entry");
        for (int i = 0; i < 31; i++) div_cyc(1'b0, E_DIV_WAIT, "div_wait");
        div_cyc(1'b0, E_DIV_DONE, "div_done");

        // Back-to-back divide with busywait for 3 cycles at counter=10
        div_cyc(1'b0, E_DIV_IN, "div2_entry");
        for (int i = 0; i < 21; i++) div_cyc(1'b0, E_DIV_WAIT, "div2_wait_a");
        for (int i = 0; i < 3; i++) div_cyc(1'b1, E_DIV_FRZ, "div2_frozen");
        for (int i = 0; i < 10; i++) div_cyc(1'b0, E_DIV_WAIT, "div2_wait_b");
        div_cyc(1'b0, E_DIV_DONE, "div2_done");
        idle(E_IDLE, "div2_after");

        // Asynchronous reset mid-divide
        div_cyc(1'b0, E_DIV_IN, "div3_entry");
        for (int i = 0; i < 4; i++) div_cyc(1'b0, E_DIV_WAIT, "div3_wait");
        #2;
        RESET_N = 1'b0;
        DIV_OP_IDEX = 1'b0;
        expect_now(E_IDLE, "async_reset");
        @(negedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) idle(E_IDLE, "post_async_reset");

        // Pending flush cleared by reset must not fire after release
        vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE, "pend2_first");
        vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_PEND, "pend2_hold");
        #2;
        RESET_N = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        expect_now(E_IDLE, "pend2_reset");
        @(negedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) idle(E_IDLE, "pend2_no_flush");

        @(posedge CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
